// File: rtl/calc_pkg.sv
//------------------------------------------------------------------------------
// Module  : calc_pkg
// Purpose : Shared widths, converter state encoding and display blank code.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package calc_pkg;

  localparam int CALC_IN_WIDTH = 17;
  localparam int CALC_DIGITS   = 6;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] BCD_BLANK = 4'hF;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
//------------------------------------------------------------------------------
// Module  : bcd_digit_adjust
// Purpose : Double-dabble nibble correction: add 3 when the digit is >= 5.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_digit_adjust (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

`default_nettype wire

// File: rtl/result_bcd_converter.sv
//------------------------------------------------------------------------------
// Module  : result_bcd_converter
// Purpose : Iterative binary-to-BCD converter with start/busy/done handshake.
//           Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module result_bcd_converter
  import calc_pkg::*;
#(
  parameter int IN_WIDTH = CALC_IN_WIDTH,
  parameter int DIGITS   = CALC_DIGITS
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   number_in,
  input  logic                  sign_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  sign_out
);

  localparam int ACC_W  = 4 * DIGITS;
  localparam int WORK_W = ACC_W + IN_WIDTH;
  localparam int CNT_W  = $clog2(IN_WIDTH + 1);

  state_t             state;
  logic [WORK_W-1:0]  work;
  logic [CNT_W-1:0]   count;
  logic               sign_cap;
  logic [ACC_W-1:0]   adjusted;
  logic [WORK_W-1:0]  next_work;
  logic [ACC_W-1:0]   final_digits;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit_in  (work[IN_WIDTH + 4*g +: 4]),
      .digit_out (adjusted[4*g +: 4])
    );
  end

  // Accumulator and binary share one register so the shift carries the binary MSB in.
  assign next_work = {adjusted, work[IN_WIDTH-1:0]} << 1;

  always_comb begin
    final_digits = next_work[WORK_W-1 -: ACC_W];
`ifdef LEADING_ZERO_BLANK_EN
    begin : blank_scan
      logic seen;
      seen = 1'b0;
      for (int i = DIGITS - 1; i > 0; i--) begin
        if (!seen && final_digits[4*i +: 4] == 4'd0)
          final_digits[4*i +: 4] = BCD_BLANK;
        else
          seen = 1'b1;
      end
    end
`endif
  end

  assign busy = (state == ST_SHIFT);

  always_ff @(posedge clk) begin
    if (!clear) begin
      state    <= ST_IDLE;
      work     <= '0;
      count    <= '0;
      sign_cap <= 1'b0;
      digits   <= '0;
      sign_out <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            work     <= {{ACC_W{1'b0}}, number_in};
            sign_cap <= sign_in;
            count    <= CNT_W'(IN_WIDTH);
            state    <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          work  <= next_work;
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            digits   <= final_digits;
            sign_out <= sign_cap;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/result_bcd_converter.md
Name: result_bcd_converter

Overview:
Sequential binary-to-BCD converter on the output side of the calculator ALU. It accepts the 17-bit ALU result magnitude and its sign flag, then runs an iterative shift-add-3 (double-dabble) conversion. It presents 6 packed BCD digits plus the sign to the display driver, using a start/busy/done handshake.

Parameters:
IN_WIDTH, 17, width of binary magnitude input; matches ALU result width.
DIGITS, 6, number of BCD output digits; must satisfy 10^DIGITS > 2^IN_WIDTH - 1.

Ports:
clk  input  1  system clock; all state changes on rising edge.
clear  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
start  input  1  request a conversion; sampled only when the block can accept (IDLE or DONE).
number_in  input  IN_WIDTH  unsigned magnitude to convert; captured on the accepted start.
sign_in  input  1  negative flag from the ALU (1 = negative); captured with number_in.
busy  output  1  high while conversion is in progress (SHIFT state).
done  output  1  one-cycle pulse when digits and sign_out are valid.
digits  output  4*DIGITS  packed BCD, digit 0 in [3:0] (units), most significant digit in top nibble.
sign_out  output  1  registered copy of the captured sign_in.

Behaviour:
- Reset (clear=0 at a rising edge): state to IDLE; busy=0, done=0, digits=0, sign_out=0; shift register and counter cleared. Reset overrides all other inputs.
- Reset mid-conversion aborts the conversion; no done pulse is produced.
- State IDLE:
  - start=1: load number_in into the binary shift register; clear the BCD accumulator; capture sign_in; load counter=IN_WIDTH; go to SHIFT.
  - start=0: stay in IDLE.
- State SHIFT, busy=1, once per cycle:
  - Every accumulator nibble >= 5 gets +3.
  - The combined {accumulator, binary} register shifts left by 1.
  - The counter decrements.
  - After the IN_WIDTH-th shift, go to DONE.
- State DONE, lasting exactly 1 cycle:
  - done=1; digits and sign_out are updated from the accumulator on entry to DONE.
  - start=1 in DONE is accepted exactly as in IDLE, allowing back-to-back conversions; otherwise go to IDLE.
- Latency: start accepted at edge N; done is high during the cycle after edge N+IN_WIDTH (17 SHIFT cycles, then DONE).
- start while busy=1 is ignored; number_in and sign_in changes during SHIFT have no effect.
- digits and sign_out hold their last value until the next DONE or reset, including through IDLE and subsequent SHIFT cycles.
- number_in is treated as unsigned magnitude; sign is never folded into the digits.
- Zero input yields all-zero digits.
- The maximum input (2^17-1 = 131071) must convert without overflow into the top digit.
- Accumulator width is 4*DIGITS; no bits are lost during the shifts.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: on entry to DONE, every leading zero digit above digit 0 is replaced with 4'hF (blank code for the display decoder). Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: digits are raw BCD with leading zeros.
- Handshake timing is identical in both builds.

Decomposition:
- Package calc_pkg holds:
  - constants CALC_IN_WIDTH=17 and CALC_DIGITS=6;
  - state typedef/localparams ST_IDLE, ST_SHIFT, ST_DONE;
  - BCD_BLANK=4'hF.
- One natural sub-module, bcd_digit_adjust: combinational per-nibble add-3-if->=5, instantiated DIGITS times via generate.

Test Plan:
- Reset: clear=0 for 3 cycles with start=1 -> busy=0, done=0, digits=0, sign_out=0 throughout.
- number_in=8, sign_in=0, start pulse -> done after exactly 18 cycles; digits=24'h000008, sign_out=0; busy high for 17 cycles.
- number_in=65536 (ALU 65535+1) -> digits=24'h065536. number_in=131071 -> digits=24'h131071. number_in=0 -> digits=24'h000000.
- number_in=10, sign_in=1 (ALU 16-26) -> digits=24'h000010, sign_out=1. Next conversion of number_in=10, sign_in=0 -> sign_out returns to 0.
- start re-asserted with new number_in=999 mid-SHIFT -> ignored; first result unchanged. start asserted in the DONE cycle -> second conversion begins; its done arrives 18 cycles later with digits=24'h000999.
- clear=0 at cycle 5 of SHIFT -> no done pulse; outputs zero. A following start for 1234 -> digits=24'h001234. With LEADING_ZERO_BLANK_EN defined, 1234 -> digits=24'hFF1234 and 0 -> 24'hFFFFF0.
